call_ret_ctrl: RTL and testbench

CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

---
 rtl/call_ret_pkg.sv | 13 +
 rtl/call_ret_ctrl.sv | 156 +++++++++++++++
 tb/tb_call_ret_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/call_ret_pkg.sv
// Shared defaults and FSM state encoding for the call/return controller.
package call_ret_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RET_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

endpackage

// File: rtl/call_ret_ctrl.sv
// Call/return sequencer driving an external return-address stack.
// Define CALL_RET_DEPTH_CHECK_EN to track stack depth and trap overflow/underflow.
module call_ret_ctrl
  import call_ret_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] stk_rdata,
  output logic              push,
  output logic              pop,
  output logic [ADDR_W-1:0] stk_wdata,
  output logic              pc_load,
  output logic [ADDR_W-1:0] next_pc,
  output logic              stall,
  output logic              overflow,
  output logic              underflow,
  output logic              illegal
);

  state_t state, state_nxt;
  logic   illegal_set;

`ifdef CALL_RET_DEPTH_CHECK_EN
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic [DEPTH_W-1:0] depth;
  logic               overflow_set, underflow_set;
  logic               overflow_q, underflow_q;
`else
  logic unused_depth_param;
  assign unused_depth_param = (DEPTH > 0);
`endif

  // Outputs are combinational so a call redirects in the same cycle it is seen.
  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    pop         = 1'b0;
    pc_load     = 1'b0;
    stall       = 1'b0;
    next_pc     = '0;
    stk_wdata   = '0;
    illegal_set = 1'b0;
`ifdef CALL_RET_DEPTH_CHECK_EN
    overflow_set  = 1'b0;
    underflow_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (instr_valid) begin
          if (is_call && is_ret) begin
            illegal_set = 1'b1;
            stall       = 1'b1;
            state_nxt   = ERR;
          end else if (is_call) begin
`ifdef CALL_RET_DEPTH_CHECK_EN
            if (depth == DEPTH_W'(DEPTH)) begin
              overflow_set = 1'b1;
              stall        = 1'b1;
              state_nxt    = ERR;
            end else
`endif
            begin
              push      = 1'b1;
              stk_wdata = pc + ADDR_W'(1);
              pc_load   = 1'b1;
              next_pc   = target;
            end
          end else if (is_ret) begin
`ifdef CALL_RET_DEPTH_CHECK_EN
            if (depth == '0) begin
              underflow_set = 1'b1;
              stall         = 1'b1;
              state_nxt     = ERR;
            end else
`endif
            begin
              stall     = 1'b1;
              state_nxt = RET_WAIT;
            end
          end
        end
      end
      RET_WAIT: begin
        pop       = 1'b1;
        pc_load   = 1'b1;
        next_pc   = stk_rdata;
        state_nxt = IDLE;
      end
      ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Reset silences everything, including a return caught mid-flight.
    if (rst) begin
      push        = 1'b0;
      pop         = 1'b0;
      pc_load     = 1'b0;
      stall       = 1'b0;
      next_pc     = '0;
      stk_wdata   = '0;
      illegal_set = 1'b0;
`ifdef CALL_RET_DEPTH_CHECK_EN
      overflow_set  = 1'b0;
      underflow_set = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      illegal <= illegal | illegal_set;
    end
  end

`ifdef CALL_RET_DEPTH_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      depth       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        depth <= depth + DEPTH_W'(1);
      end else if (pop) begin
        depth <= depth - DEPTH_W'(1);
      end
      overflow_q  <= overflow_q | overflow_set;
      underflow_q <= underflow_q | underflow_set;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Self-checking bench for call_ret_ctrl; expectations follow CALL_RET_DEPTH_CHECK_EN.
module tb_call_ret_ctrl;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid, is_call, is_ret;
  logic [ADDR_W-1:0] pc, target, stk_rdata;
  logic              push, pop, pc_load, stall;
  logic [ADDR_W-1:0] stk_wdata, next_pc;
  logic              overflow, underflow, illegal;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string             name;
    logic              v, c, r;
    logic [ADDR_W-1:0] pc, tgt, rd;
    logic              e_push, e_pop, e_load, e_stall;
    logic [ADDR_W-1:0] e_next, e_wdata;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  call_ret_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .is_call(is_call), .is_ret(is_ret),
    .pc(pc), .target(target), .stk_rdata(stk_rdata), .push(push), .pop(pop),
    .stk_wdata(stk_wdata), .pc_load(pc_load), .next_pc(next_pc), .stall(stall),
    .overflow(overflow), .underflow(underflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic r,
                       input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] t,
                       input logic [ADDR_W-1:0] rd);
    instr_valid = v;
    is_call     = c;
    is_ret      = r;
    pc          = p;
    target      = t;
    stk_rdata   = rd;
  endtask

  // Scoreboard side: pop the oldest expectation and compare against live outputs.
  task automatic check_output();
    vec_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".push"}, push, e.e_push);
    check({e.name, ".pop"}, pop, e.e_pop);
    check({e.name, ".pc_load"}, pc_load, e.e_load);
    check({e.name, ".stall"}, stall, e.e_stall);
    if (e.e_load) check({e.name, ".next_pc"}, next_pc, e.e_next);
    if (e.e_push) check({e.name, ".stk_wdata"}, stk_wdata, e.e_wdata);
  endtask

  task automatic apply_stimulus(input vec_t t);
    @(posedge clk); #1;
    drive(t.v, t.c, t.r, t.pc, t.tgt, t.rd);
    sb.push_back(t);
    @(negedge clk);
    check_output();
  endtask

  task automatic cycle(input logic v, input logic c, input logic r,
                       input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] t,
                       input logic [ADDR_W-1:0] rd);
    @(posedge clk); #1;
    drive(v, c, r, p, t, rd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Return issued while the tracked depth is zero.
  task automatic ret_at_empty(input string tag);
    cycle(1, 0, 1, 12'h300, '0, 12'h0AA);
    check({tag, ".accept_push"}, push, 1'b0);
    check({tag, ".accept_pop"}, pop, 1'b0);
    check({tag, ".accept_load"}, pc_load, 1'b0);
    cycle(0, 0, 0, '0, '0, 12'h0AA);
`ifdef CALL_RET_DEPTH_CHECK_EN
    check({tag, ".underflow"}, underflow, 1'b1);
    check({tag, ".stall_err"}, stall, 1'b1);
    check({tag, ".no_pop"}, pop, 1'b0);
    check({tag, ".no_load"}, pc_load, 1'b0);
`else
    check({tag, ".underflow"}, underflow, 1'b0);
    check({tag, ".pop"}, pop, 1'b1);
    check({tag, ".load"}, pc_load, 1'b1);
    check({tag, ".next_pc"}, next_pc, 12'h0AA);
`endif
  endtask

  function automatic vec_t mk(input string n, input logic v, input logic c, input logic r,
                              input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] t,
                              input logic [ADDR_W-1:0] rd, input logic ep, input logic eo,
                              input logic el, input logic es, input logic [ADDR_W-1:0] en,
                              input logic [ADDR_W-1:0] ew);
    vec_t x;
    x.name = n; x.v = v; x.c = c; x.r = r; x.pc = p; x.tgt = t; x.rd = rd;
    x.e_push = ep; x.e_pop = eo; x.e_load = el; x.e_stall = es; x.e_next = en; x.e_wdata = ew;
    return x;
  endfunction

  initial begin
    logic exp_push;
    int   pushes;

    //           name       v  c  r  pc       tgt      rd       push pop load stall next     wdata
    vecs.push_back(mk("idle_nv",   0, 1, 0, 12'h050, 12'h060, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000));
    vecs.push_back(mk("call1",     1, 1, 0, 12'h010, 12'h200, 12'h000, 1, 0, 1, 0, 12'h200, 12'h011));
    vecs.push_back(mk("ret1_acc",  1, 0, 1, 12'h201, 12'h000, 12'h000, 0, 0, 0, 1, 12'h000, 12'h000));
    vecs.push_back(mk("ret1_wait", 1, 1, 0, 12'h777, 12'h666, 12'h011, 0, 1, 1, 0, 12'h011, 12'h000));
    vecs.push_back(mk("call_wrap", 1, 1, 0, 12'hFFF, 12'h123, 12'h000, 1, 0, 1, 0, 12'h123, 12'h000));
    vecs.push_back(mk("call2",     1, 1, 0, 12'h0AB, 12'h456, 12'h000, 1, 0, 1, 0, 12'h456, 12'h0AC));
    vecs.push_back(mk("ret2_acc",  1, 0, 1, 12'h457, 12'h000, 12'h000, 0, 0, 0, 1, 12'h000, 12'h000));
    vecs.push_back(mk("ret2_wait", 0, 0, 0, 12'h000, 12'h000, 12'h0AC, 0, 1, 1, 0, 12'h0AC, 12'h000));
    vecs.push_back(mk("ret3_acc",  1, 0, 1, 12'h0AD, 12'h000, 12'h000, 0, 0, 0, 1, 12'h000, 12'h000));
    vecs.push_back(mk("ret3_wait", 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 1, 1, 0, 12'h000, 12'h000));
    vecs.push_back(mk("idle_ret",  0, 0, 1, 12'h010, 12'h000, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000));

    // Reset state, with a call presented so any leakage would show.
    rst = 1'b1;
    drive(1, 1, 0, 12'h010, 12'h200, 12'h000);
    @(negedge clk);
    @(negedge clk);
    check("rst.push", push, 1'b0);
    check("rst.pc_load", pc_load, 1'b0);
    check("rst.stall", stall, 1'b0);
    check("rst.next_pc", next_pc, 12'h000);
    check("rst.stk_wdata", stk_wdata, 12'h000);
    check("rst.flags", {overflow, underflow, illegal}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, '0, '0, '0);

    foreach (vecs[i]) apply_stimulus(vecs[i]);
    check("sb_drained", sb.size(), 0);

    ret_at_empty("ret_empty");
    do_reset();

    // Nine back-to-back calls against an eight-entry stack.
    pushes = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1, 1, 0, ADDR_W'(i * 16), ADDR_W'(12'h400 + i), '0);
`ifdef CALL_RET_DEPTH_CHECK_EN
      exp_push = (i < 8);
`else
      exp_push = 1'b1;
`endif
      check($sformatf("call9[%0d].push", i), push, exp_push);
      check($sformatf("call9[%0d].load", i), pc_load, exp_push);
      if (push) pushes++;
    end
    cycle(1, 1, 0, 12'h500, 12'h600, '0);
`ifdef CALL_RET_DEPTH_CHECK_EN
    check("call9.pushes", pushes, 8);
    check("call9.overflow", overflow, 1'b1);
    check("call9.stall", stall, 1'b1);
    check("call9.no_push_in_err", push, 1'b0);
    cycle(0, 0, 0, '0, '0, '0);
    check("call9.stall_held", stall, 1'b1);
`else
    check("call9.pushes", pushes, 9);
    check("call9.overflow", overflow, 1'b0);
    check("call9.stall", stall, 1'b0);
`endif
    do_reset();

    // Simultaneous call and return is trapped until reset.
    cycle(1, 1, 1, 12'h020, 12'h300, '0);
    check("illegal.push", push, 1'b0);
    check("illegal.pop", pop, 1'b0);
    check("illegal.load", pc_load, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 12'h030, 12'h310, '0);
      check($sformatf("illegal[%0d].flag", i), illegal, 1'b1);
      check($sformatf("illegal[%0d].stall", i), stall, 1'b1);
      check($sformatf("illegal[%0d].push", i), push, 1'b0);
    end
    do_reset();
    @(negedge clk);
    check("illegal.cleared", illegal, 1'b0);
    check("illegal.stall_cleared", stall, 1'b0);

    // Reset landing in RET_WAIT must abandon the return and clear the depth.
    cycle(1, 1, 0, 12'h040, 12'h500, '0);
    check("rstwait.call_push", push, 1'b1);
    cycle(1, 0, 1, 12'h500, '0, '0);
    check("rstwait.accept_stall", stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, 12'h041);
    @(negedge clk);
    check("rstwait.pop", pop, 1'b0);
    check("rstwait.pc_load", pc_load, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, '0, '0, '0);
    ret_at_empty("rstwait_after");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
